// File: rtl/switch_port_arbiter.sv
// Round-robin per-output arbiter for the 4-port switch; grants are held for a whole packet.
// Optional macro ARB_TIMEOUT_EN adds a per-output hold limit (MAX_HOLD) with forced release.
module switch_port_arbiter #(
  parameter int NPORTS   = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        valid_in,
  input  logic [8*NPORTS-1:0]      addr_in,
  input  logic [NPORTS-1:0]        rcv_rdy,
  output logic [NPORTS*NPORTS-1:0] out_sel,
  output logic [NPORTS-1:0]        in_gnt,
  output logic [NPORTS-1:0]        port_busy,
  output logic [NPORTS-1:0]        timeout_evt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q [NPORTS];
  state_t            state_d [NPORTS];
  logic [1:0]        src_q   [NPORTS];
  logic [1:0]        src_d   [NPORTS];
  logic [1:0]        rr_q    [NPORTS];
  logic [1:0]        rr_d    [NPORTS];
  logic [NPORTS-1:0] req     [NPORTS];
  logic [NPORTS-1:0] gnt;
  logic [NPORTS-1:0] blocked;
  logic              unused_addr_bits;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0]     cnt_q [NPORTS];
  logic [CW-1:0]     cnt_d [NPORTS];
  logic [NPORTS-1:0] blocked_q;
  logic [NPORTS-1:0] block_set;
  logic [NPORTS-1:0] evt_d;
  assign blocked = blocked_q;
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign blocked     = '0;
  assign timeout_evt = '0;
`endif

  // First requester at or after ptr, wrapping through the 2-bit index.
  function automatic logic [1:0] pick(input logic [NPORTS-1:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    gnt       = '0;
    out_sel   = '0;
    port_busy = '0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      if (state_q[o] == HOLD) begin
        gnt[src_q[o]]                  = 1'b1;
        port_busy[o]                   = 1'b1;
        out_sel[NPORTS*o +: NPORTS]    = NPORTS'(1) << src_q[o];
      end
    end
  end

  assign in_gnt = gnt;

  always_comb begin
    unused_addr_bits = 1'b0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        req[o][i] = valid_in[i] && (addr_in[8*i +: 2] == 2'(o)) && !gnt[i] && !blocked[i];
      end
      unused_addr_bits = unused_addr_bits ^ (^addr_in[8*o+2 +: 6]);
    end
  end

  always_comb begin
`ifdef ARB_TIMEOUT_EN
    block_set = '0;
    evt_d     = '0;
`endif
    for (int unsigned o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      src_d[o]   = src_q[o];
      rr_d[o]    = rr_q[o];
`ifdef ARB_TIMEOUT_EN
      cnt_d[o]   = '0;
`endif
      case (state_q[o])
        IDLE: begin
          if (rcv_rdy[o] && (|req[o])) begin
            state_d[o] = HOLD;
            src_d[o]   = pick(req[o], rr_q[o]);
          end
        end
        HOLD: begin
          if (!valid_in[src_q[o]]) begin
            state_d[o] = IDLE;
            rr_d[o]    = src_q[o] + 2'd1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q[o] == CW'(MAX_HOLD - 1)) begin
            state_d[o]          = IDLE;
            rr_d[o]             = src_q[o] + 2'd1;
            evt_d[o]            = 1'b1;
            block_set[src_q[o]] = 1'b1;
          end else begin
            cnt_d[o] = cnt_q[o] + 1'b1;
          end
`endif
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        src_q[o]   <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        src_q[o]   <= src_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // A force-released input stays masked until its packet finally ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned o = 0; o < NPORTS; o++) cnt_q[o] <= '0;
      blocked_q   <= '0;
      timeout_evt <= '0;
    end else begin
      for (int unsigned o = 0; o < NPORTS; o++) cnt_q[o] <= cnt_d[o];
      blocked_q   <= (blocked_q | block_set) & valid_in;
      timeout_evt <= evt_d;
    end
  end
`endif

endmodule

// File: doc/switch_port_arbiter.md
# switch_port_arbiter

Per-output-port arbiter for the 4-port packet switch. Each of the 4 input ports presents a valid request and an 8-bit address byte; the block decodes the destination output port and grants each output to at most one input at a time, using round-robin fairness. Grants are held for a whole packet and gated by the receiver's ready. The crossbar datapath consumes the one-hot select vectors to steer addr/data/valid from input to output.

## Interface
Parameters:
- NPORTS, 4: number of input and output ports (fixed at 4 in this revision).
- MAX_HOLD, 16: maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- valid_in  input  4  per-input request; high for the full packet duration.
- addr_in  input  32  4 x 8-bit address bytes, input i at [8i+7:8i]; destination port = byte bits [1:0].
- rcv_rdy  input  4  per-output receiver ready.
- out_sel  output  16  4 x 4-bit one-hot source select; output o at [4o+3:4o]; all zero when idle.
- in_gnt  output  4  input i currently granted to some output.
- port_busy  output  4  output o is held by a grant.
- timeout_evt  output  4  one-cycle pulse when output o is force-released (ARB_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- Each output o runs an independent 2-state FSM: IDLE, HOLD.
- Request r[i][o] = valid_in[i] && addr_in[8i+1:8i]==o && !in_gnt[i].
- IDLE -> HOLD: requires some r[*][o] and rcv_rdy[o]. The winner is the first requester at or after rr_ptr[o], scanning upward with wrap 3->0. Register src[o] = winner, then set out_sel[o] and in_gnt[src].
- HOLD: the destination is latched; addr_in[src] changes are ignored. A rcv_rdy[o] drop mid-packet does not revoke the grant, because flow control belongs to the datapath.
- HOLD -> IDLE: when valid_in[src[o]] is sampled low. Clear out_sel[o] and set rr_ptr[o] = src+1 mod 4.
- An input holds at most one grant. Since each input decodes to exactly one destination, grants cannot conflict across outputs.
- Reset (any cycle, including mid-packet): all FSMs to IDLE; out_sel, in_gnt, port_busy, timeout_evt = 0; rr_ptr[o] = 0.

## Timing
- Grant latency: a request sampled at edge N produces out_sel/in_gnt/port_busy valid after edge N (registered), so they are visible in cycle N+1.
- Release: valid_in low sampled at edge M clears the grant after edge M.
- Re-grant on the same output happens at edge M+1 at the earliest. There is one mandatory idle cycle between packets on the same output.
- Simultaneous requests on the same output: round-robin decides, and exactly one grant is issued.
- A request while rcv_rdy[o]=0 in IDLE is held off with no grant. It is granted at the first edge where rcv_rdy[o]=1.
- Requests to different outputs are granted in the same cycle, independently.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ARB_TIMEOUT_EN defined: a per-output hold counter (width clog2(MAX_HOLD)+1) clears on grant and increments each HOLD cycle.
  - When the count reaches MAX_HOLD, the output is force-released to IDLE, timeout_evt[o] pulses for one cycle, and rr_ptr advances past src.
  - The source stays blocked (treated as granted) until its valid_in drops. This prevents an immediate re-grant of the stuck packet.
- ARB_TIMEOUT_EN undefined: no counter and no blocking logic; grants are held indefinitely; timeout_evt tied 0.

## Test plan
- Reset: assert reset=0 mid-packet with out_sel[0]=4'b0010 -> all outputs 0 after the next edge, rr_ptr=0.
- Single request: valid_in=4'b0001, addr_in byte0=8'h02, rcv_rdy=4'hF -> one edge later out_sel[2]=4'b0001, in_gnt=4'b0001, port_busy=4'b0100. Drop valid -> all clear after the edge.
- Contention/fairness: inputs 0,1,3 all target port 1 with back-to-back packets of 3 cycles each -> grant order 0,1,3,0, with one idle cycle between each.
- Parallel: input0->port3 and input2->port0 in the same cycle -> both granted on the same edge.
- Backpressure: rcv_rdy[1]=0 with a request to port 1 -> no grant for 5 cycles; raise rcv_rdy -> grant next edge. Drop rcv_rdy mid-packet -> grant held.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): hold valid_in[2] for 30 cycles -> release after 16 HOLD cycles with a single timeout_evt pulse; input 2 is not re-granted until its valid_in drops.
